// File: rtl/arb_mux_nto1_pkg.sv
// Shared definitions for the N-to-1 arbitrated multiplexer.
package arb_mux_nto1_pkg;

  // Arbitration policy selected by the RR_MODE parameter.
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Next channel index after idx, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_mux_nto1_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// above ptr, wrapping from N_IN-1 back to 0. Pointer storage lives in the
// parent so this block stays purely combinational.
module rr_arbiter #(
  parameter int N_IN = 4,
  parameter int SELW = $clog2(N_IN)
) (
  input  logic [N_IN-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [N_IN-1:0] grant,
  output logic [SELW-1:0] idx
);

  logic            found_s;
  logic [SELW-1:0] cand_s;

  // Scan requests starting at ptr and take the first one found.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < N_IN; k++) begin
      cand_s = SELW'((int'(ptr) + k) % N_IN);
      if (!found_s && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        idx           = cand_s;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/arb_mux_nto1.sv
// N-to-1 multiplexer with valid/ready handshake, registered output stage
// and either software-selected or round-robin arbitration.
module arb_mux_nto1
  import arb_mux_nto1_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int N_IN    = 4,
  parameter  int RR_MODE = 1,
  localparam int SELW    = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       out_src
);

  localparam arb_mode_e MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_src_r;
  logic [SELW-1:0]  rr_ptr_r;

  logic             load_en_s;
  logic             accept_s;
  logic [N_IN-1:0]  rr_grant_s;
  logic [SELW-1:0]  rr_idx_s;
  logic [N_IN-1:0]  fix_grant_s;
  logic [N_IN-1:0]  grant_s;
  logic [SELW-1:0]  grant_idx_s;
  logic [WIDTH-1:0] data_sel_s;

  rr_arbiter #(
    .N_IN (N_IN),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (rr_ptr_r),
    .grant (rr_grant_s),
    .idx   (rr_idx_s)
  );

  // Fixed-select grant; an out-of-range sel grants nobody.
  always_comb begin
    fix_grant_s = '0;
    if (int'(sel) < N_IN) begin
      fix_grant_s[sel] = in_valid[sel];
    end else begin
      fix_grant_s = '0;
    end
  end

  // Pick the grant source for the configured arbitration policy.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    if (MODE == ARB_RR) begin
      grant_s     = rr_grant_s;
      grant_idx_s = rr_idx_s;
    end else begin
      grant_s     = fix_grant_s;
      grant_idx_s = sel;
    end
  end

  // Output register can take a new word when empty or being drained now.
  assign load_en_s = !out_valid_r || out_ready;
  // Ready is withheld during reset so nothing is lost while the stage clears.
  assign in_ready  = (rst_n && load_en_s) ? grant_s : {N_IN{1'b0}};
  assign accept_s  = |in_ready;

  // Route the granted channel's data; grant is one-hot so at most one hit.
  always_comb begin
    data_sel_s = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_s[i]) begin
        data_sel_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        data_sel_s = data_sel_s;
      end
    end
  end

  // Output stage and round-robin pointer; pointer only moves on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_src_r   <= '0;
      rr_ptr_r    <= '0;
    end else begin
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= data_sel_s;
        out_src_r   <= grant_idx_s;
        if (MODE == ARB_RR) begin
          rr_ptr_r <= SELW'(wrap_inc(int'(grant_idx_s), N_IN));
        end else begin
          rr_ptr_r <= rr_ptr_r;
        end
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;

endmodule

// File: tb/tb_arb_mux_nto1.sv
// Scoreboard bench for arb_mux_nto1: one round-robin and one fixed-select
// instance. Stimulus pushes hand-computed {src,data} words; a monitor thread
// pops and compares on every output transfer.
module tb_arb_mux_nto1;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] r_in_data,  f_in_data;
  logic [3:0]  r_in_valid, f_in_valid;
  logic [3:0]  r_in_ready, f_in_ready;
  logic [1:0]  r_sel,      f_sel;
  logic [7:0]  r_out_data, f_out_data;
  logic        r_out_valid, f_out_valid;
  logic        r_out_ready, f_out_ready;
  logic [1:0]  r_out_src,  f_out_src;

  int checks = 0;
  int errors = 0;
  logic [9:0] q_r[$];
  logic [9:0] q_f[$];

  always #5 clk = ~clk;

  arb_mux_nto1 #(.WIDTH(8), .N_IN(4), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(r_in_data), .in_valid(r_in_valid),
    .in_ready(r_in_ready), .sel(r_sel), .out_data(r_out_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_src(r_out_src)
  );

  arb_mux_nto1 #(.WIDTH(8), .N_IN(4), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_data(f_in_data), .in_valid(f_in_valid),
    .in_ready(f_in_ready), .sel(f_sel), .out_data(f_out_data),
    .out_valid(f_out_valid), .out_ready(f_out_ready), .out_src(f_out_src)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_r(input logic [1:0] src, input logic [7:0] d);
    q_r.push_back({src, d});
  endtask

  task automatic push_f(input logic [1:0] src, input logic [7:0] d);
    q_f.push_back({src, d});
  endtask

  logic [3:0] exp_rdy[5];
  logic [9:0] e;

  initial begin
    rst_n       = 1'b0;
    r_in_data   = 32'h0;   f_in_data   = 32'h0;
    r_in_valid  = 4'hF;    f_in_valid  = 4'hF;
    r_sel       = 2'd0;    f_sel       = 2'd0;
    r_out_ready = 1'b1;    f_out_ready = 1'b1;

    fork
      begin : stim
        // Reset held two cycles with every channel requesting.
        step();
        step();
        @(negedge clk);
        chk("rst_rr_in_ready", 32'(r_in_ready), 32'h0);
        chk("rst_rr_out_valid", 32'(r_out_valid), 32'h0);
        chk("rst_rr_out_data", 32'(r_out_data), 32'h0);
        chk("rst_rr_out_src", 32'(r_out_src), 32'h0);
        chk("rst_fx_in_ready", 32'(f_in_ready), 32'h0);
        chk("rst_fx_out_valid", 32'(f_out_valid), 32'h0);
        f_in_valid = 4'h0;
        step();

        // Round-robin fairness with all channels requesting.
        r_in_data = {8'h33, 8'h22, 8'h11, 8'h00};
        r_in_valid = 4'b1111;
        push_r(2'd0, 8'h00); push_r(2'd1, 8'h11); push_r(2'd2, 8'h22);
        push_r(2'd3, 8'h33); push_r(2'd0, 8'h00);
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("fair_ready_%0d", k), 32'(r_in_ready), 32'(exp_rdy[k]));
          step();
        end
        r_in_valid = 4'h0;
        step(); step();

        // Skip idle channels: only 1 and 3 request, starting from reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        r_in_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        r_in_valid = 4'b1010;
        push_r(2'd1, 8'hB1); push_r(2'd3, 8'hB3);
        push_r(2'd1, 8'hB1); push_r(2'd3, 8'hB3);
        exp_rdy[0] = 4'b0010; exp_rdy[1] = 4'b1000;
        exp_rdy[2] = 4'b0010; exp_rdy[3] = 4'b1000;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk($sformatf("skip_ready_%0d", k), 32'(r_in_ready), 32'(exp_rdy[k]));
          step();
        end
        r_in_valid = 4'h0;
        step(); step();

        // Back-pressure: A5 from ch2 held while the consumer stalls.
        r_in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        r_in_valid = 4'b0100;
        push_r(2'd2, 8'hA5); push_r(2'd2, 8'h5A);
        @(negedge clk);
        chk("bp_first_ready", 32'(r_in_ready), 32'h4);
        step();
        r_out_ready = 1'b0;
        r_in_data = {8'h00, 8'h5A, 8'h00, 8'h00};
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk($sformatf("bp_data_%0d", k), 32'(r_out_data), 32'hA5);
          chk($sformatf("bp_src_%0d", k), 32'(r_out_src), 32'h2);
          chk($sformatf("bp_valid_%0d", k), 32'(r_out_valid), 32'h1);
          chk($sformatf("bp_ready_%0d", k), 32'(r_in_ready), 32'h0);
          step();
        end
        r_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(r_in_ready), 32'h4);
        step();
        r_in_valid = 4'h0;
        step(); step();

        // Reset mid-transfer: ch3 word pending, then discarded.
        r_out_ready = 1'b0;
        r_in_data = {8'hC3, 8'h00, 8'h00, 8'h00};
        r_in_valid = 4'b1000;
        step();
        r_in_valid = 4'h0;
        @(negedge clk);
        chk("mid_pending_valid", 32'(r_out_valid), 32'h1);
        chk("mid_pending_src", 32'(r_out_src), 32'h3);
        rst_n = 1'b0;
        r_in_valid = 4'hF;
        #1;
        chk("mid_rst_ready", 32'(r_in_ready), 32'h0);
        step();
        @(negedge clk);
        chk("mid_rst_valid", 32'(r_out_valid), 32'h0);
        chk("mid_rst_data", 32'(r_out_data), 32'h0);

        // Pointer moved to 2 by a ch1 accept, then reset must restart at ch0.
        rst_n = 1'b1;
        r_in_valid = 4'b0010;
        step();
        rst_n = 1'b0;
        r_in_valid = 4'h0;
        step();
        rst_n = 1'b1;
        r_out_ready = 1'b1;
        r_in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        r_in_valid = 4'hF;
        push_r(2'd0, 8'hD0);
        @(negedge clk);
        chk("rst_ptr_ready", 32'(r_in_ready), 32'h1);
        step();
        r_in_valid = 4'h0;
        step(); step();

        // Fixed select: sel=2 served every cycle, then sel=1 with ch1 idle.
        f_in_data = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
        f_in_valid = 4'b1111;
        f_sel = 2'd2;
        push_f(2'd2, 8'hF2); push_f(2'd2, 8'hF2); push_f(2'd2, 8'hF2);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk($sformatf("fx_ready_%0d", k), 32'(f_in_ready), 32'h4);
          step();
        end
        f_sel = 2'd1;
        f_in_valid = 4'b1101;
        @(negedge clk);
        chk("fx_idle_ready", 32'(f_in_ready), 32'h0);
        step();
        @(negedge clk);
        chk("fx_drained_valid", 32'(f_out_valid), 32'h0);
        step();
      end
      begin : monitor
        forever begin
          @(negedge clk);
          if (rst_n && r_out_valid && r_out_ready) begin
            if (q_r.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rr_unexpected: got src %0d data %0h expected no word", r_out_src, r_out_data);
            end else begin
              e = q_r.pop_front();
              chk("rr_out_src", 32'(r_out_src), 32'(e[9:8]));
              chk("rr_out_data", 32'(r_out_data), 32'(e[7:0]));
            end
          end
          if (rst_n && f_out_valid && f_out_ready) begin
            if (q_f.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL fx_unexpected: got src %0d data %0h expected no word", f_out_src, f_out_data);
            end else begin
              e = q_f.pop_front();
              chk("fx_out_src", 32'(f_out_src), 32'(e[9:8]));
              chk("fx_out_data", 32'(f_out_data), 32'(e[7:0]));
            end
          end
        end
      end
    join_any
    disable fork;

    chk("rr_queue_drained", 32'(q_r.size()), 32'h0);
    chk("fx_queue_drained", 32'(q_f.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
